// File: rtl/trail_pkg.sv
// rtl/trail_pkg.sv - shared constants, state enum and length clamp for the trail buffer
// Contents:
//   DIR_*        move direction encoding on i_dir
//   state_t      trail FSM state (ST_IDLE / ST_RUN)
//   DEF_*        default start point and grid size
//   clamp_len    maps a requested length onto 1..depth
package trail_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_RIGHT = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DEF_START_X = 16;
    localparam int DEF_START_Y = 12;
    localparam int DEF_GRID_W  = 32;
    localparam int DEF_GRID_H  = 24;

    function automatic logic [6:0] clamp_len(input logic [6:0] v, input int depth);
        if (v == 7'd0) begin
            return 7'd1;
        end
        if (int'(v) > depth) begin
            return 7'(depth);
        end
        return v;
    endfunction

endpackage

// File: rtl/trail_buffer_if.sv
// rtl/trail_buffer_if.sv - control and trail-state bundle between a game controller and trail_buffer
// Signals:
//   i_clear, i_max_len      new-round pulse and length sampled with it
//   i_step, i_dir           one-cycle move strobe and its direction
//   o_trail_x/o_trail_y     flat slot arrays, slot i at [i*COORD_W +: COORD_W]
//   o_slot_valid, o_len     occupancy mask and count
//   o_head_x/o_head_y       current head
//   o_collide, o_blocked    one-cycle event pulses
// Modports: master drives the controls, slave is the buffer.
interface trail_buffer_if #(
    parameter int DEPTH   = 32,
    parameter int COORD_W = 5
);
    logic                       i_clear;
    logic                       i_step;
    logic [1:0]                 i_dir;
    logic [6:0]                 i_max_len;
    logic [DEPTH*COORD_W-1:0]   o_trail_x;
    logic [DEPTH*COORD_W-1:0]   o_trail_y;
    logic [DEPTH-1:0]           o_slot_valid;
    logic [COORD_W-1:0]         o_head_x;
    logic [COORD_W-1:0]         o_head_y;
    logic [6:0]                 o_len;
    logic                       o_collide;
    logic                       o_blocked;

    modport master (
        output i_clear, i_step, i_dir, i_max_len,
        input  o_trail_x, o_trail_y, o_slot_valid, o_head_x, o_head_y,
               o_len, o_collide, o_blocked
    );

    modport slave (
        input  i_clear, i_step, i_dir, i_max_len,
        output o_trail_x, o_trail_y, o_slot_valid, o_head_x, o_head_y,
               o_len, o_collide, o_blocked
    );
endinterface

// File: rtl/trail_cmp.sv
// rtl/trail_cmp.sv - parallel head-versus-slot match, purely combinational
// Ports:
//   i_slot_x/i_slot_y  flat slot arrays
//   i_valid            per-slot occupancy
//   i_head_x/i_head_y  point to look for
//   o_hit              1 when any valid slot equals the point
module trail_cmp #(
    parameter int DEPTH   = 32,
    parameter int COORD_W = 5
) (
    input  logic [DEPTH*COORD_W-1:0] i_slot_x,
    input  logic [DEPTH*COORD_W-1:0] i_slot_y,
    input  logic [DEPTH-1:0]         i_valid,
    input  logic [COORD_W-1:0]       i_head_x,
    input  logic [COORD_W-1:0]       i_head_y,
    output logic                     o_hit
);
    logic [DEPTH-1:0] w_match;

    always_comb begin
        w_match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_match[i] = i_valid[i]
                      && (i_slot_x[i*COORD_W +: COORD_W] == i_head_x)
                      && (i_slot_y[i*COORD_W +: COORD_W] == i_head_y);
        end
    end

    assign o_hit = |w_match;
endmodule

// File: rtl/trail_buffer.sv
// rtl/trail_buffer.sv - ring buffer of recent head positions with edge blocking and self-collision detect
// Ports:
//   i_clk   clock, all state on its rising edge
//   i_rst   synchronous active-high reset (eff_len = DEPTH afterwards)
//   bus     trail_buffer_if slave: clear/step/dir/max_len in, trail state and pulses out
module trail_buffer
    import trail_pkg::*;
#(
    parameter int COORD_W = 5,
    parameter int DEPTH   = 32,
    parameter int GRID_W  = DEF_GRID_W,
    parameter int GRID_H  = DEF_GRID_H,
    parameter int START_X = DEF_START_X,
    parameter int START_Y = DEF_START_Y
) (
    input  logic           i_clk,
    input  logic           i_rst,
    trail_buffer_if.slave  bus
);
    localparam int                 PW    = $clog2(DEPTH);
    localparam logic [COORD_W-1:0] SX    = COORD_W'(START_X);
    localparam logic [COORD_W-1:0] SY    = COORD_W'(START_Y);
    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(GRID_H - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [COORD_W-1:0]   r_slot_x [DEPTH];
    logic [COORD_W-1:0]   r_slot_y [DEPTH];
    logic [DEPTH-1:0]     r_valid;
    logic [COORD_W-1:0]   r_head_x;
    logic [COORD_W-1:0]   r_head_y;
    logic [PW-1:0]        r_wr_ptr;
    logic [6:0]           r_len;
    logic [6:0]           r_eff_len;
    logic                 r_collide;
    logic                 r_blocked;

    logic                 w_in_grid;
    logic [COORD_W-1:0]   w_nxt_x;
    logic [COORD_W-1:0]   w_nxt_y;
    logic                 w_cmd;
    logic                 w_accept;
    logic                 w_refuse;
    logic [COORD_W-1:0]   w_wr_x;
    logic [COORD_W-1:0]   w_wr_y;
    logic [PW-1:0]        w_ptr_adv;
    logic [DEPTH*COORD_W-1:0] w_trail_x;
    logic [DEPTH*COORD_W-1:0] w_trail_y;
    logic [DEPTH*COORD_W-1:0] w_post_x;
    logic [DEPTH*COORD_W-1:0] w_post_y;
    logic [DEPTH-1:0]     w_post_valid;
    logic                 w_hit;

    // Candidate head and whether it stays on the grid.
    always_comb begin
        w_in_grid = 1'b1;
        w_nxt_x   = r_head_x;
        w_nxt_y   = r_head_y;
        case (bus.i_dir)
            DIR_UP:    begin w_in_grid = (r_head_y != '0);   w_nxt_y = r_head_y - 1'b1; end
            DIR_DOWN:  begin w_in_grid = (r_head_y != Y_MAX); w_nxt_y = r_head_y + 1'b1; end
            DIR_RIGHT: begin w_in_grid = (r_head_x != X_MAX); w_nxt_x = r_head_x + 1'b1; end
            DIR_LEFT:  begin w_in_grid = (r_head_x != '0);   w_nxt_x = r_head_x - 1'b1; end
        endcase
    end

    assign w_cmd    = bus.i_step && !i_rst && !bus.i_clear;
    assign w_accept = w_cmd && w_in_grid;
    assign w_refuse = w_cmd && !w_in_grid;

    // The first move of a round records the start point itself.
    assign w_wr_x    = (r_state == ST_IDLE) ? SX : r_head_x;
    assign w_wr_y    = (r_state == ST_IDLE) ? SY : r_head_y;
    // ">=" keeps the pointer inside the ring even for eff_len = 1.
    assign w_ptr_adv = (7'(r_wr_ptr) >= r_eff_len - 7'd1) ? '0 : r_wr_ptr + 1'b1;

    // Current contents, then the contents as they will be after this step's write.
    always_comb begin
        w_trail_x = '0;
        w_trail_y = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_trail_x[i*COORD_W +: COORD_W] = r_slot_x[i];
            w_trail_y[i*COORD_W +: COORD_W] = r_slot_y[i];
        end
        w_post_x     = w_trail_x;
        w_post_y     = w_trail_y;
        w_post_valid = r_valid;
        w_post_x[r_wr_ptr*COORD_W +: COORD_W] = w_wr_x;
        w_post_y[r_wr_ptr*COORD_W +: COORD_W] = w_wr_y;
        w_post_valid[r_wr_ptr]                = 1'b1;
    end

    trail_cmp #(
        .DEPTH   (DEPTH),
        .COORD_W (COORD_W)
    ) u_cmp (
        .i_slot_x (w_post_x),
        .i_slot_y (w_post_y),
        .i_valid  (w_post_valid),
        .i_head_x (w_nxt_x),
        .i_head_y (w_nxt_y),
        .o_hit    (w_hit)
    );

    always_comb begin
        w_state_nxt = r_state;
        if (bus.i_clear) begin
            w_state_nxt = ST_IDLE;
        end else if (w_accept) begin
            w_state_nxt = ST_RUN;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                r_slot_x[i] <= '1;
                r_slot_y[i] <= '1;
            end
            r_valid   <= '0;
            r_head_x  <= SX;
            r_head_y  <= SY;
            r_wr_ptr  <= '0;
            r_len     <= '0;
            r_eff_len <= 7'(DEPTH);
            r_collide <= 1'b0;
            r_blocked <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_collide <= w_accept && w_hit;
            r_blocked <= w_refuse;
            if (bus.i_clear) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_slot_x[i] <= '1;
                    r_slot_y[i] <= '1;
                end
                r_valid   <= '0;
                r_head_x  <= SX;
                r_head_y  <= SY;
                r_wr_ptr  <= '0;
                r_len     <= '0;
                r_eff_len <= clamp_len(bus.i_max_len, DEPTH);
            end else if (w_accept) begin
                r_slot_x[r_wr_ptr] <= w_wr_x;
                r_slot_y[r_wr_ptr] <= w_wr_y;
                r_valid[r_wr_ptr]  <= 1'b1;
                r_head_x           <= w_nxt_x;
                r_head_y           <= w_nxt_y;
                r_wr_ptr           <= w_ptr_adv;
                if (r_len < r_eff_len) begin
                    r_len <= r_len + 7'd1;
                end
            end
        end
    end

    assign bus.o_trail_x    = w_trail_x;
    assign bus.o_trail_y    = w_trail_y;
    assign bus.o_slot_valid = r_valid;
    assign bus.o_head_x     = r_head_x;
    assign bus.o_head_y     = r_head_y;
    assign bus.o_len        = r_len;
    assign bus.o_collide    = r_collide;
    assign bus.o_blocked    = r_blocked;
endmodule

// File: tb/tb_trail_buffer.sv
// tb/tb_trail_buffer.sv - directed self-checking bench for trail_buffer
module tb_trail_buffer;
    import trail_pkg::*;

    localparam int DEPTH = 32;
    localparam int CW    = 5;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_col   = 0;
    int   n_blk   = 0;
    logic last_col;
    logic last_blk;

    always #5 clk = ~clk;

    trail_buffer_if #(.DEPTH(DEPTH), .COORD_W(CW)) bus ();

    trail_buffer #(.COORD_W(CW), .DEPTH(DEPTH)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [CW-1:0] sx(input int i);
        return bus.o_trail_x[i*CW +: CW];
    endfunction

    function automatic logic [CW-1:0] sy(input int i);
        return bus.o_trail_y[i*CW +: CW];
    endfunction

    // Called at a falling edge; returns at the next falling edge with the step applied.
    task automatic step(input logic [1:0] d);
        bus.i_step = 1'b1;
        bus.i_dir  = d;
        @(negedge clk);
        bus.i_step = 1'b0;
        last_col   = bus.o_collide;
        last_blk   = bus.o_blocked;
        if (bus.o_collide) n_col++;
        if (bus.o_blocked) n_blk++;
    endtask

    task automatic clear(input logic [6:0] ml);
        bus.i_clear   = 1'b1;
        bus.i_max_len = ml;
        @(negedge clk);
        bus.i_clear   = 1'b0;
        n_col = 0;
        n_blk = 0;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_len"},   bus.o_len, 0);
        chk({tag, "_valid"}, bus.o_slot_valid, 0);
        chk({tag, "_hx"},    bus.o_head_x, 16);
        chk({tag, "_hy"},    bus.o_head_y, 12);
        chk({tag, "_ones"},  {&bus.o_trail_x, &bus.o_trail_y}, 2'b11);
        chk({tag, "_col"},   bus.o_collide, 0);
        chk({tag, "_blk"},   bus.o_blocked, 0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.i_clear   = 1'b0;
        bus.i_step    = 1'b0;
        bus.i_dir     = DIR_UP;
        bus.i_max_len = 7'd0;
        @(negedge clk);
        chk_cleared("reset");
        rst = 1'b0;

        // First move after reset
        step(DIR_RIGHT);
        chk("first_s0x", sx(0), 16);
        chk("first_s0y", sy(0), 12);
        chk("first_hx",  bus.o_head_x, 17);
        chk("first_hy",  bus.o_head_y, 12);
        chk("first_len", bus.o_len, 1);
        chk("first_val", bus.o_slot_valid, 32'h1);
        chk("first_s1x", sx(1), 31);

        // Wrap with length 3
        clear(7'd3);
        for (int i = 0; i < 5; i++) step(DIR_RIGHT);
        chk("wrap_len", bus.o_len, 3);
        chk("wrap_val", bus.o_slot_valid, 32'h7);
        chk("wrap_s0x", sx(0), 19);
        chk("wrap_s1x", sx(1), 20);
        chk("wrap_s2x", sx(2), 18);
        chk("wrap_s2y", sy(2), 12);
        chk("wrap_s3x", sx(3), 31);
        chk("wrap_hx",  bus.o_head_x, 21);
        chk("wrap_col", n_col, 0);

        // Square loop with length 8 closes on the start point
        clear(7'd8);
        step(DIR_RIGHT); step(DIR_DOWN); step(DIR_LEFT);
        chk("sq_nocol3", n_col, 0);
        step(DIR_UP);
        chk("sq_col4", last_col, 1);
        chk("sq_ncol", n_col, 1);
        chk("sq_hx",   bus.o_head_x, 16);
        chk("sq_hy",   bus.o_head_y, 12);
        chk("sq_len",  bus.o_len, 4);
        @(negedge clk);
        chk("sq_pulse1", bus.o_collide, 0);

        // Same loop with length 3: the matching point was just overwritten
        clear(7'd3);
        step(DIR_RIGHT); step(DIR_DOWN); step(DIR_LEFT); step(DIR_UP);
        chk("ovw_col", n_col, 0);
        chk("ovw_s0x", sx(0), 16);
        chk("ovw_s0y", sy(0), 13);

        // max_len 0 behaves as 1
        clear(7'd0);
        step(DIR_RIGHT); step(DIR_RIGHT);
        chk("len0_len", bus.o_len, 1);
        chk("len0_val", bus.o_slot_valid, 32'h1);
        chk("len0_s0x", sx(0), 17);
        chk("len0_hx",  bus.o_head_x, 18);

        // Top edge
        clear(7'd32);
        for (int i = 0; i < 12; i++) step(DIR_UP);
        chk("top_hy",  bus.o_head_y, 0);
        chk("top_len", bus.o_len, 12);
        step(DIR_UP);
        chk("top_blk",  last_blk, 1);
        chk("top_hy2",  bus.o_head_y, 0);
        chk("top_hx2",  bus.o_head_x, 16);
        chk("top_len2", bus.o_len, 12);
        chk("top_val",  bus.o_slot_valid, 32'hFFF);
        chk("top_s11y", sy(11), 1);
        chk("top_s12y", sy(12), 31);
        chk("top_col",  n_col, 0);
        @(negedge clk);
        chk("top_pulse1", bus.o_blocked, 0);
        chk("top_nblk",   n_blk, 1);

        // Right edge
        clear(7'd32);
        for (int i = 0; i < 15; i++) step(DIR_RIGHT);
        chk("rt_hx", bus.o_head_x, 31);
        step(DIR_RIGHT);
        chk("rt_blk", last_blk, 1);
        chk("rt_hx2", bus.o_head_x, 31);
        chk("rt_len", bus.o_len, 15);

        // clear and step together at the edge: clear wins, no pulses
        bus.i_clear   = 1'b1;
        bus.i_max_len = 7'd8;
        bus.i_step    = 1'b1;
        bus.i_dir     = DIR_RIGHT;
        @(negedge clk);
        bus.i_clear = 1'b0;
        bus.i_step  = 1'b0;
        chk_cleared("clrstep");
        @(negedge clk);
        chk("clrstep_col2", bus.o_collide, 0);
        chk("clrstep_blk2", bus.o_blocked, 0);
        step(DIR_DOWN);
        chk("clrstep_s0y", sy(0), 12);
        chk("clrstep_hy",  bus.o_head_y, 13);
        chk("clrstep_len", bus.o_len, 1);

        // rst mid-run with step high
        step(DIR_DOWN); step(DIR_LEFT);
        rst        = 1'b1;
        bus.i_step = 1'b1;
        bus.i_dir  = DIR_LEFT;
        @(negedge clk);
        bus.i_step = 1'b0;
        chk_cleared("midrst");
        rst = 1'b0;

        // After rst the ring spans DEPTH: snake of 33 steps saturates and wraps once
        for (int i = 0; i < 15; i++) step(DIR_RIGHT);
        step(DIR_DOWN);
        for (int i = 0; i < 17; i++) step(DIR_LEFT);
        chk("snake_len", bus.o_len, 32);
        chk("snake_val", bus.o_slot_valid, 32'hFFFF_FFFF);
        chk("snake_s0x", sx(0), 15);
        chk("snake_s0y", sy(0), 13);
        chk("snake_s1x", sx(1), 17);
        chk("snake_hx",  bus.o_head_x, 14);
        chk("snake_hy",  bus.o_head_y, 13);
        chk("snake_col", n_col, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
